// File: rtl/imem_loader.sv
// Boot loader: byte stream -> 16-bit instruction memory words, holds core in reset.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [16:0] DEPTH_V = 17'(1 << ADDR_W);

  typedef enum logic [2:0] {
    S_CNT_LO,
    S_CNT_HI,
    S_DAT_LO,
    S_DAT_HI,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t            r_state;
  state_t            w_next;
  logic              w_ready;
  logic              w_accept;
  logic              w_wr;
  logic [15:0]       r_count;
  logic [15:0]       w_cnt_full;
  logic [ADDR_W:0]   r_idx;
  logic [ADDR_W:0]   w_idx_nxt;
  logic              w_last;
  logic [7:0]        r_lo;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_mem_wdata;
  logic              r_core_rst;
  logic              r_load_done;
  logic              r_load_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  assign w_cnt_full = {in_data, r_count[7:0]};
  assign w_idx_nxt  = r_idx + 1'b1;
  assign w_last     = (17'(w_idx_nxt) == {1'b0, r_count});

  always_comb begin
    w_ready = 1'b0;
    unique case (1'b1)
      (r_state == S_CNT_LO): w_ready = 1'b1;
      (r_state == S_CNT_HI): w_ready = 1'b1;
      (r_state == S_DAT_LO): w_ready = 1'b1;
      (r_state == S_DAT_HI): w_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      (r_state == S_CSUM):   w_ready = 1'b1;
`endif
      default:               w_ready = 1'b0;
    endcase
  end

  assign in_ready = w_ready && !rst;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_CNT_LO;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_wr   = 1'b0;
    unique case (r_state)
      S_CNT_LO: begin
        if (w_accept) w_next = S_CNT_HI;
      end
      S_CNT_HI: begin
        if (w_accept) begin
          if ({1'b0, w_cnt_full} > DEPTH_V)
            w_next = S_ERR;
          else if (w_cnt_full == 16'd0)
            w_next = S_TAIL;
          else
            w_next = S_DAT_LO;
        end
      end
      S_DAT_LO: begin
        if (w_accept) w_next = S_DAT_HI;
      end
      S_DAT_HI: begin
        if (w_accept) begin
          w_wr   = 1'b1;
          w_next = w_last ? S_TAIL : S_DAT_LO;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_accept)
          w_next = (in_data == r_csum) ? S_DONE : S_ERR;
      end
`endif
      S_DONE:  w_next = S_DONE;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_idx       <= '0;
      r_lo        <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= w_wr;
      if (w_accept) begin
        unique case (r_state)
          S_CNT_LO: r_count[7:0]  <= in_data;
          S_CNT_HI: r_count[15:8] <= in_data;
          S_DAT_LO: r_lo          <= in_data;
          S_DAT_HI: begin
            r_mem_addr  <= r_idx[ADDR_W-1:0];
            r_mem_wdata <= {in_data, r_lo};
            r_idx       <= w_idx_nxt;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR of every accepted byte, count bytes included.
  always_ff @(posedge clk) begin
    if (rst)           r_csum <= '0;
    else if (w_accept) r_csum <= r_csum ^ in_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_core_rst  <= 1'b1;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_core_rst  <= (r_state != S_DONE);
      r_load_done <= (r_state == S_DONE);
      r_load_err  <= (r_state == S_ERR);
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign core_rst  = r_core_rst;
  assign load_done = r_load_done;
  assign load_err  = r_load_err;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a stream-level reference model.
// Honours IMEM_LOADER_CHECKSUM_EN the same way as the design.
module tb_imem_loader;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          core_rst;
  logic          load_done;
  logic          load_err;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst(core_rst), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // write monitor
  int w_addr[$];
  int w_data[$];
  int w_cyc[$];
  int done_cyc = -1;
  int err_cyc = -1;
  int ovl = 0;
  bit prev_we = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        w_addr.push_back(int'(mem_addr));
        w_data.push_back(int'(mem_wdata));
        w_cyc.push_back(cyc);
        if (prev_we) ovl++;
        if (!core_rst) ovl++;
      end
      if (core_rst == load_done) ovl++;
      prev_we = mem_we;
      if (load_done && done_cyc < 0) done_cyc = cyc;
      if (load_err && err_cyc < 0) err_cyc = cyc;
    end else begin
      prev_we = 0;
    end
  end

  task automatic clr_mon();
    w_addr.delete();
    w_data.delete();
    w_cyc.delete();
    done_cyc = -1;
    err_cyc = -1;
    ovl = 0;
  endtask

  // reference model: expected writes, accepted bytes, outcome (1 done, 2 err)
  int e_addr[$];
  int e_data[$];
  int e_acc;
  int e_res;

  task automatic model(input bq_t s);
    int n;
    logic [7:0] x;
    e_addr.delete();
    e_data.delete();
    n = int'(s[0]) + 256 * int'(s[1]);
    if (n > DEPTH) begin
      e_acc = 2;
      e_res = 2;
    end else begin
      for (int k = 0; k < n; k++) begin
        e_addr.push_back(k);
        e_data.push_back(int'(s[3+2*k]) * 256 + int'(s[2+2*k]));
      end
      e_acc = 2 + 2 * n;
      e_res = 1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      x = 8'h00;
      for (int i = 0; i < 2 + 2 * n; i++) x = x ^ s[i];
      e_acc = e_acc + 1;
      e_res = (s[2+2*n] == x) ? 1 : 2;
`else
      x = 8'h00;
`endif
    end
  endtask

  function automatic bq_t mk(input int n, input bit good);
    bq_t q;
    logic [7:0] x;
    logic [7:0] b;
    q.push_back(n[7:0]);
    q.push_back(n[15:8]);
    if (n <= DEPTH)
      for (int i = 0; i < 2 * n; i++) begin
        b = 8'($urandom);
        q.push_back(b);
      end
    x = 8'h00;
    foreach (q[i]) x = x ^ q[i];
    if (!good) x = x ^ 8'($urandom_range(1, 255));
`ifdef IMEM_LOADER_CHECKSUM_EN
    q.push_back(x);
`endif
    return q;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'($urandom);
    in_data = 8'($urandom);
    repeat (2) @(negedge clk);
    check("rst:in_ready", in_ready, 0);
    check("rst:mem_we", mem_we, 0);
    check("rst:mem_addr", mem_addr, 0);
    check("rst:mem_wdata", mem_wdata, 0);
    check("rst:core_rst", core_rst, 1);
    check("rst:load_done", load_done, 0);
    check("rst:load_err", load_err, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    clr_mon();
  endtask

  task automatic run_stream(input bq_t s, input int maxgap, input string tag);
    bq_t all;
    int acc;
    int acyc[$];
    bit stop;
    int late;
    int nw;
    model(s);
    all = s;
    repeat (3) all.push_back(8'($urandom));
    acc = 0;
    stop = 0;
    late = 0;
    foreach (all[i]) begin
      if (stop) break;
      repeat ($urandom_range(0, maxgap)) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 8'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data = all[i];
      #1;
      if (in_ready) begin
        acc++;
        acyc.push_back(cyc);
      end else begin
        stop = 1;
        repeat (3) begin
          @(negedge clk);
          #1;
          if (in_ready) late++;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check({tag, ":acc"}, acc, e_acc);
    check({tag, ":stop"}, 32'(stop), 1);
    check({tag, ":hold"}, late, 0);
    check({tag, ":nwr"}, w_addr.size(), e_addr.size());
    nw = (w_addr.size() < e_addr.size()) ? w_addr.size() : e_addr.size();
    for (int k = 0; k < nw; k++) begin
      check({tag, ":addr"}, w_addr[k], e_addr[k]);
      check({tag, ":data"}, w_data[k], e_data[k]);
      if (3 + 2 * k < acyc.size())
        check({tag, ":wlat"}, w_cyc[k], acyc[3+2*k] + 1);
    end
    check({tag, ":done"}, load_done, 32'(e_res == 1));
    check({tag, ":err"}, load_err, 32'(e_res == 2));
    check({tag, ":core_rst"}, core_rst, 32'(e_res != 1));
    check({tag, ":in_ready"}, in_ready, 0);
    check({tag, ":ovl"}, ovl, 0);
    if (acyc.size() == e_acc) begin
      if (e_res == 1) check({tag, ":done_lat"}, done_cyc, acyc[e_acc-1] + 2);
      else            check({tag, ":err_lat"}, err_cyc, acyc[e_acc-1] + 2);
    end
  endtask

  initial begin
    bq_t s;
    int t;
    int n;

    s = '{};
    s.push_back(8'h02); s.push_back(8'h00);
    s.push_back(8'h34); s.push_back(8'h12);
    s.push_back(8'h78); s.push_back(8'h56);
`ifdef IMEM_LOADER_CHECKSUM_EN
    s.push_back(8'h0A);
`endif
    do_reset();
    run_stream(s, 0, "basic");
    do_reset();
    run_stream(s, 5, "gaps");

`ifdef IMEM_LOADER_CHECKSUM_EN
    s[6] = 8'hFF;
    do_reset();
    run_stream(s, 2, "badsum");
`endif

    s = '{};
    s.push_back(8'h00); s.push_back(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    s.push_back(8'h00);
`endif
    do_reset();
    run_stream(s, 1, "empty");

    s = '{};
    s.push_back(8'h01); s.push_back(8'h04);
    do_reset();
    run_stream(s, 1, "oversize");

    // reset right after the first word is written
    do_reset();
    s = '{};
    s.push_back(8'h02); s.push_back(8'h00);
    s.push_back(8'h34); s.push_back(8'h12);
    foreach (s[i]) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = s[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (w_addr.size() == 0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("midrst:first_wr", w_addr.size(), 1);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h05;
    @(negedge clk);
    check("midrst:core_rst", core_rst, 1);
    check("midrst:in_ready", in_ready, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    clr_mon();
    #1;
    check("midrst:ready_again", in_ready, 1);
    s = '{};
    s.push_back(8'h01); s.push_back(8'h00);
    s.push_back(8'hCD); s.push_back(8'hAB);
`ifdef IMEM_LOADER_CHECKSUM_EN
    s.push_back(8'h67);
`endif
    run_stream(s, 2, "midrst");

    do_reset();
    run_stream(mk(DEPTH, 1), 0, "full");
    do_reset();
    run_stream(mk(DEPTH + 1, 1), 0, "full+1");

    for (int r = 0; r < 24; r++) begin
      if ($urandom_range(0, 5) == 0) n = $urandom_range(DEPTH + 1, 65535);
      else                           n = $urandom_range(0, 8);
      do_reset();
      run_stream(mk(n, $urandom_range(0, 3) != 0), 3, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction memory writer for the 16-bit pipelined core. It receives a byte stream over a valid/ready handshake and assembles little-endian 16-bit instruction words. It writes those words into the instruction memory that the fetch stage reads, and holds the core in reset until the image is fully written. It sits between the external byte source and the instruction memory write port, and drives the core-wide reset.

## Interface
Parameters:
- ADDR_W, 10, instruction memory word-address width; capacity DEPTH = 2^ADDR_W words

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction memory write strobe, one-cycle pulse
- mem_addr  out  ADDR_W  word address (equals fetch PC[ADDR_W:1])
- mem_wdata  out  16  instruction word
- core_rst  out  1  active-high reset to the processor pipeline
- load_done  out  1  image loaded successfully, sticky until rst
- load_err  out  1  image rejected, sticky until rst

## Operation
- Stream format:
  - count low byte, then count high byte (16-bit word count N)
  - N words, each sent low byte then high byte
  - a checksum byte, present only when CHECKSUM is compiled in (see Configuration)
- A byte is accepted on a clock edge where in_valid && in_ready.
- States: CNT_LO, CNT_HI, DAT_LO, DAT_HI, CSUM (only when compiled in), DONE, ERR. Reset enters CNT_LO.
- in_ready = 1 in CNT_LO, CNT_HI, DAT_LO, DAT_HI, CSUM; 0 in DONE, ERR and while rst = 1.
- CNT_LO: latch count[7:0] and go to CNT_HI.
- CNT_HI: latch count[15:8], then:
  - count > DEPTH: go to ERR
  - count == 0: go to CSUM if compiled in, otherwise DONE
  - otherwise: go to DAT_LO
- DAT_LO: latch the low byte and go to DAT_HI.
- DAT_HI: register mem_we = 1, mem_addr = word index, mem_wdata = {hi, lo}, and increment the word index (ADDR_W+1 bits, starts at 0). If the index reaches N, go to CSUM/DONE; otherwise go to DAT_LO.
- Addresses never wrap. The count > DEPTH rejection guarantees the index stays below DEPTH.
- mem_addr and mem_wdata hold their last value between writes.
- No stall path: a write always completes in the pulse cycle.
- DONE and ERR are terminal until rst. Bytes offered in these states are not accepted.
- Reset mid-load:
  - returns to CNT_LO, clears the index, count and checksum, and reasserts core_rst
  - memory words already written are left as-is; the next load overwrites them
  - the byte presented in the rst cycle is not accepted

## Timing
- Reset values: in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, core_rst 1, load_done 0, load_err 0.
- Write latency: mem_we is high for exactly the one cycle following the edge that accepts a word's high byte.
- Minimum spacing between writes is 2 cycles, because each word takes 2 accepted bytes.
- core_rst and load_done are registered from state:
  - core_rst falls, and load_done rises, one edge after DONE is entered
  - so the last mem_we pulse always completes before core_rst deasserts
- load_err rises one edge after ERR is entered; core_rst stays 1 in ERR.
- in_valid bubbles of any length only delay progress; they have no other effect.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - CSUM state is present
  - a running XOR covers every accepted byte, including both count bytes
  - after the last word (or after CNT_HI when N = 0), one more byte is accepted
  - if it equals the running XOR: go to DONE; otherwise go to ERR
  - all memory writes have already occurred either way
- Not defined:
  - CSUM state and XOR logic are absent
  - the last word (or N = 0) goes directly to DONE
  - the only source of load_err is an oversize count

## Test plan
- Stream 02 00 34 12 78 56 (plus 0A with checksum) -> writes addr 0 = 0x1234, addr 1 = 0x5678, each a 1-cycle mem_we. core_rst 1->0 and load_done 1. Further bytes see in_ready 0.
- Same stream with random in_valid gaps of 0-5 cycles -> identical writes and identical final state.
- Stream 00 00 (plus 00 with checksum) -> no mem_we, load_done 1, core_rst 0.
- Stream 01 04 (N = 0x0401, ADDR_W = 10) -> ERR after the second byte: load_err 1, in_ready 0, no writes, core_rst stays 1.
- Checksum build: 02 00 34 12 78 56 FF -> both writes occur, load_err 1, core_rst stays 1. The same stream with 0A -> load_done 1.
- rst pulsed for 1 cycle right after the first word's write, then a full fresh stream 01 00 CD AB (plus 67) -> state restarts at CNT_LO, addr 0 = 0xABCD, load_done 1.
